// File: rtl/tunnel_wall_gen.sv
// Tunnel playfield generator: 128-row ring buffer of left-wall columns, scrolled by an
// LFSR random walk, mapped to per-pixel wall codes plus a per-frame crash flag.
`timescale 1ns/1ps
module tunnel_wall_gen #(
  parameter int unsigned MAP_COLS   = 160,
  parameter int unsigned GAP_WIDTH  = 48,
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       video_on,
  input  logic [9:0] pixel_row,
  input  logic [9:0] pixel_column,
  input  logic [2:0] speed,
  input  logic [6:0] icon_row,
  input  logic [7:0] icon_col,
  output logic [1:0] wall,
  output logic       crash,
  output logic       ready
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [7:0]  L_INIT   = 8'((MAP_COLS - GAP_WIDTH) / 2);
  localparam logic [7:0]  L_MIN    = 8'd1;
  localparam logic [7:0]  L_MAX    = 8'(MAP_COLS - GAP_WIDTH - 2);
  localparam logic [8:0]  GAP      = 9'(GAP_WIDTH);
  localparam logic [7:0]  VIS_ROWS = 8'd120;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_GEN, S_WRITE} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head, r_init_ptr, w_head_dec;
  logic [15:0]           r_lfsr;
  logic [2:0]            r_frame_cnt;
  logic [3:0]            w_cnt_inc;
  logic [7:0]            r_nxt, w_nxt, w_cur_left;
  logic                  r_crash, r_ready;
  logic                  w_tick, w_fire, w_crash_eval;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_waddr, w_pix_addr, w_icon_addr;
  logic [7:0]            w_wdata;
  logic [7:0]            w_mrow, w_mcol;
  logic [7:0]            r_rd_left, r_icon_left;
  logic                  r_s1_vis;
  logic [7:0]            r_s1_mcol;
  logic [8:0]            w_s1_mcol9, w_lo_edge, w_hi_edge, w_icon_col9;
  logic [1:0]            r_wall;

  assign wall  = r_wall;
  assign crash = r_crash;
  assign ready = r_ready;

  assign w_mrow      = pixel_row[9:2];
  assign w_mcol      = pixel_column[9:2];
  assign w_tick      = (pixel_row == 10'd480) && (pixel_column == 10'd0);
  assign w_head_dec  = r_head - 1'b1;
  assign w_pix_addr  = r_head + w_mrow[DEPTH_LOG2-1:0];
  assign w_icon_addr = r_head + icon_row[DEPTH_LOG2-1:0];
  assign w_cnt_inc   = {1'b0, r_frame_cnt} + 4'd1;
  assign w_fire      = (speed != 3'd0) && (w_cnt_inc >= (4'd8 - {1'b0, speed}));

  // Crash uses the icon-row read captured on the clock before the tick, i.e. pre-scroll rows.
  assign w_icon_col9  = {1'b0, icon_col};
  assign w_crash_eval = (w_icon_col9 <= ({1'b0, r_icon_left} - 9'd1)) ||
                        (w_icon_col9 >= ({1'b0, r_icon_left} + GAP));

  always_comb begin
    w_cur_left = r_mem[r_head];
    case (r_lfsr[1:0])
      2'b00:   w_nxt = (w_cur_left <= L_MIN) ? L_MIN : w_cur_left - 8'd1;
      2'b10:   w_nxt = (w_cur_left >= L_MAX) ? L_MAX : w_cur_left + 8'd1;
      default: w_nxt = w_cur_left;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_init_ptr;
    w_wdata     = L_INIT;
    case (r_state)
      S_INIT: begin
        w_we = 1'b1;
        if (r_init_ptr == '1) w_state_nxt = S_IDLE;
      end
      S_IDLE:  if (w_tick && w_fire) w_state_nxt = S_GEN;
      S_GEN:   w_state_nxt = S_WRITE;
      S_WRITE: begin
        w_we        = 1'b1;
        w_waddr     = w_head_dec;
        w_wdata     = r_nxt;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_init_ptr  <= '0;
      r_head      <= '0;
      r_frame_cnt <= '0;
      r_lfsr      <= 16'hACE1;
      r_nxt       <= '0;
      r_crash     <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      if (r_state == S_INIT) begin
        r_init_ptr <= r_init_ptr + 1'b1;
        if (r_init_ptr == '1) r_ready <= 1'b1;
      end
      if (r_state == S_IDLE && w_tick) begin
        r_crash     <= w_crash_eval;
        r_frame_cnt <= w_fire ? '0 : w_cnt_inc[2:0];
      end
      if (r_state == S_GEN)   r_nxt  <= w_nxt;
      if (r_state == S_WRITE) r_head <= w_head_dec;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd_left   <= r_mem[w_pix_addr];
    r_icon_left <= r_mem[w_icon_addr];
  end

  assign w_s1_mcol9 = {1'b0, r_s1_mcol};
  assign w_lo_edge  = {1'b0, r_rd_left} - 9'd1;
  assign w_hi_edge  = {1'b0, r_rd_left} + GAP;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_s1_vis  <= 1'b0;
      r_s1_mcol <= '0;
      r_wall    <= 2'b00;
    end else begin
      r_s1_vis  <= video_on && (w_mrow < VIS_ROWS) && r_ready;
      r_s1_mcol <= w_mcol;
      if (!r_s1_vis)
        r_wall <= 2'b00;
      else if (w_s1_mcol9 == w_lo_edge || w_s1_mcol9 == w_hi_edge)
        r_wall <= 2'b10;
      else if (w_s1_mcol9 < w_lo_edge || w_s1_mcol9 > w_hi_edge)
        r_wall <= 2'b01;
      else
        r_wall <= 2'b00;
    end
  end

endmodule

// File: tb/tb_tunnel_wall_gen.sv
// Randomized bench for tunnel_wall_gen against a queue-based playfield model.
`timescale 1ns/1ps
module tb_tunnel_wall_gen;

  logic       clock = 1'b0;
  logic       rst;
  logic       video_on;
  logic [9:0] pixel_row, pixel_column;
  logic [2:0] speed;
  logic [6:0] icon_row;
  logic [7:0] icon_col;
  logic [1:0] wall;
  logic       crash, ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int          m_rows[$];
  int          m_cnt;
  int          m_crash;
  bit          m_ready;
  logic [15:0] m_lfsr;

  int s_row[$];
  int s_col[$];
  bit s_von[$];

  always #20 clock = ~clock;

  tunnel_wall_gen #(.MAP_COLS(160), .GAP_WIDTH(48), .DEPTH_LOG2(7)) dut (
    .clock(clock), .rst(rst), .video_on(video_on),
    .pixel_row(pixel_row), .pixel_column(pixel_column), .speed(speed),
    .icon_row(icon_row), .icon_col(icon_col),
    .wall(wall), .crash(crash), .ready(ready)
  );

  // x^16 + x^14 + x^13 + x^11 + 1, one step per clock from the reset seed
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int x, b;
    x = int'(v);
    b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (b << 15));
  endfunction

  always @(posedge clock or negedge rst)
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lfsr_step(m_lfsr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wall_of(int mrow, int mcol, bit von, bit rdy);
    int l;
    if (!von || !rdy || mrow >= 120) return 0;
    l = m_rows[mrow];
    if (mcol == l - 1 || mcol == l + 48) return 2;
    if (mcol < l - 1 || mcol > l + 48) return 1;
    return 0;
  endfunction

  function automatic int crash_of(int r, int c);
    int l;
    l = m_rows[r];
    return (c <= l - 1 || c >= l + 48) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_rows.delete();
    repeat (128) m_rows.push_back(56);
    m_cnt   = 0;
    m_crash = 0;
    m_ready = 1'b0;
  endtask

  task automatic add_px(input int prow, input int pcol, input bit von);
    s_row.push_back(prow);
    s_col.push_back(pcol);
    s_von.push_back(von);
  endtask

  // Streams one pixel per clock; each wall sample is checked two clocks after its pixel.
  task automatic run_stream();
    int exp_q[$];
    int n;
    n = s_row.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clock);
      if (i >= 2) check_val("wall", 32'(wall), 32'(exp_q[i-2]));
      if (i < n) begin
        pixel_row    = 10'(s_row[i]);
        pixel_column = 10'(s_col[i]);
        video_on     = s_von[i];
        exp_q.push_back(wall_of(s_row[i] >> 2, s_col[i] >> 2, s_von[i], m_ready));
      end else begin
        video_on     = 1'b0;
        pixel_row    = 10'd500;
        pixel_column = 10'd1;
      end
    end
    s_row.delete();
    s_col.delete();
    s_von.delete();
  endtask

  task automatic probe_row(input int r);
    int l;
    int cols[7];
    l = m_rows[r];
    cols = '{l - 2, l - 1, l, l + 47, l + 48, l + 49, int'($urandom_range(0, 199))};
    foreach (cols[k])
      if (cols[k] >= 0)
        add_px(4 * r + int'($urandom_range(0, 3)), 4 * cols[k] + int'($urandom_range(0, 3)), 1'b1);
    run_stream();
  endtask

  task automatic do_tick(input int ir, input int ic);
    int d, inc, l, nxt;
    logic [1:0] sel;
    repeat ($urandom_range(0, 3)) @(negedge clock);
    @(negedge clock);
    video_on = 1'b0; icon_row = 7'(ir); icon_col = 8'(ic);
    pixel_row = 10'd0; pixel_column = 10'd1;
    @(negedge clock);
    pixel_row = 10'd480; pixel_column = 10'd0;
    @(negedge clock);
    sel = m_lfsr[1:0];
    pixel_row = 10'd481; pixel_column = 10'd1;
    m_crash = crash_of(ir, ic);
    inc = m_cnt + 1;
    if (speed != 3'd0 && inc >= 8 - int'(speed)) begin
      m_cnt = 0;
      d = (sel == 2'b00) ? -1 : (sel == 2'b10) ? 1 : 0;
      l = m_rows[0];
      nxt = l + d;
      if (nxt < 1)   nxt = 1;
      if (nxt > 110) nxt = 110;
      m_rows.push_front(nxt);
      void'(m_rows.pop_back());
    end else begin
      m_cnt = inc % 8;
    end
    @(negedge clock);
    @(negedge clock);
    check_val("crash", 32'(crash), 32'(m_crash));
  endtask

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int cols0[5];
    rst = 1'b1; video_on = 1'b0; pixel_row = 10'd0; pixel_column = 10'd1;
    speed = 3'd0; icon_row = 7'd60; icon_col = 8'd0;
    model_reset();
    @(negedge clock);
    rst = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_wall", 32'(wall), 32'd0);
    check_val("rst_crash", 32'(crash), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd0);

    // Release; a tick and a visible pixel during INIT must have no effect.
    rst = 1'b1;
    for (int k = 1; k <= 127; k++) begin
      @(negedge clock);
      if (k == 50) begin pixel_row = 10'd480; pixel_column = 10'd0; end
      if (k == 51) begin pixel_row = 10'd0;   pixel_column = 10'd1; end
      if (k == 100) begin video_on = 1'b1; pixel_row = 10'd40; pixel_column = 10'd40; end
      if (k == 103) begin check_val("init_wall", 32'(wall), 32'd0); video_on = 1'b0; end
    end
    check_val("ready_127", 32'(ready), 32'd0);
    check_val("init_tick_crash", 32'(crash), 32'd0);
    @(negedge clock);
    check_val("ready_128", 32'(ready), 32'd1);
    m_ready = 1'b1;

    // Initial pattern: left=56 everywhere.
    cols0 = '{55, 104, 80, 10, 56};
    foreach (cols0[k]) add_px(0, cols0[k] * 4, 1'b1);
    foreach (cols0[k]) add_px(60 * 4 + 1, cols0[k] * 4 + 3, 1'b1);
    foreach (cols0[k]) add_px(119 * 4 + 3, cols0[k] * 4 + 1, 1'b1);
    add_px(490, 40, 1'b1);
    add_px(100, 40, 1'b0);
    add_px(100, 44, 1'b1);
    run_stream();

    // speed=0: crash probes at row 60, ten frames with no scroll.
    speed = 3'd0;
    do_tick(60, 55);
    do_tick(60, 56);
    do_tick(60, 104);
    do_tick(60, 103);
    do_tick(60, 0);
    do_tick(60, 159);
    repeat (4) do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
    probe_row(0);
    probe_row(60);
    probe_row(119);

    // speed=7: one row per frame.
    speed = 3'd7;
    for (int f = 0; f < 200; f++) begin
      do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
      if (f % 25 == 24) begin
        probe_row(0);
        probe_row(int'($urandom_range(1, 119)));
      end
    end

    // Slower rates and a mid-count speed increase.
    speed = 3'd3;
    repeat (15) do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
    probe_row(0);
    speed = 3'd1;
    repeat (17) do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
    probe_row(0);
    speed = 3'd5;
    repeat (3) do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
    probe_row(0);
    probe_row(1);

    // Long walk at full speed so the clamps have a chance to engage.
    speed = 3'd7;
    for (int f = 0; f < 3000; f++) begin
      do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
      if (f % 60 == 59) probe_row(int'($urandom_range(0, 119)));
    end
    probe_row(0);

    // Reset in the middle of INIT.
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    model_reset();
    repeat (40) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check_val("midinit_ready", 32'(ready), 32'd0);
    check_val("midinit_wall", 32'(wall), 32'd0);
    check_val("midinit_crash", 32'(crash), 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 127; k++) begin
      @(negedge clock);
      if (k == 64) check_val("reinit_wall", 32'(wall), 32'd0);
    end
    check_val("reready_127", 32'(ready), 32'd0);
    @(negedge clock);
    check_val("reready_128", 32'(ready), 32'd1);
    m_ready = 1'b1;
    probe_row(0);
    probe_row(64);
    probe_row(119);
    speed = 3'd7;
    repeat (10) do_tick(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
    probe_row(0);
    probe_row(9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
